// File: rtl/sipo_frame_if.sv
// Serial-in / parallel-out frame bus: serial line and strobe in, assembled word
// out over valid/ready, plus status flags.
interface sipo_frame_if #(
  parameter int WIDTH = 4
);
  logic             si;
  logic             si_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic             overrun_clr;
  logic             busy;

  // master drives the serial line and consumes the word; slave is the controller
  modport master (
    output si, si_en, dout_ready, overrun_clr,
    input  dout, dout_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  si, si_en, dout_ready, overrun_clr,
    output dout, dout_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for the serial-in/parallel-out shift chain: start-bit detect,
// data shift, optional even parity, stop check and valid/ready word hand-off.
module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  sipo_frame_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_bit_q, par_bit_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             par_calc;

  assign par_calc = PARITY_EN ? ((^shift_q) ^ par_bit_q) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;

    // Consumer hand-off and overrun clear run every cycle, independent of si_en;
    // a load below overrides both where it applies.
    if (valid_q && bus.dout_ready) valid_d = 1'b0;
    if (bus.overrun_clr)           ovr_d   = 1'b0;

    if (bus.si_en) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.si) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {shift_q[WIDTH-2:0], bus.si};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_bit_d = bus.si;
          state_d   = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bus.si) begin
            if (!valid_q || bus.dout_ready) begin
              dout_d  = shift_q;
              perr_d  = par_calc;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench: a WIDTH=4 parity instance on a continuous strobe and a
// no-parity instance with a gated strobe.
module tb_sipo_frame_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sipo_frame_if #(.WIDTH(4)) ifa ();
  sipo_frame_if #(.WIDTH(4)) ifb ();

  sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b0)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic bit_a(input logic b);
    ifa.si    = b;
    ifa.si_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // start, 4 data bits MSB first, parity, stop; rdy/clr applied on the stop strobe
  task automatic frame_a(input logic [3:0] d, input logic p, input logic stop,
                         input logic rdy, input logic clr);
    bit_a(1'b0);
    for (int i = 3; i >= 0; i--) bit_a(d[i]);
    bit_a(p);
    ifa.dout_ready  = rdy;
    ifa.overrun_clr = clr;
    bit_a(stop);
    ifa.dout_ready  = 1'b0;
    ifa.overrun_clr = 1'b0;
    ifa.si          = 1'b1;
  endtask

  task automatic consume_a();
    ifa.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.dout_ready = 1'b0;
  endtask

  // one strobe then two idle cycles with si flipped; busy/valid must hold through the gap
  task automatic bit_b(input logic b, input logic exp_busy, input logic exp_valid);
    ifb.si    = b;
    ifb.si_en = 1'b1;
    @(posedge clk);
    #1;
    ifb.si_en = 1'b0;
    ifb.si    = ~b;
    check_val("b_busy_strobe", {31'd0, ifb.busy}, {31'd0, exp_busy});
    repeat (2) @(posedge clk);
    #1;
    check_val("b_busy_gap", {31'd0, ifb.busy}, {31'd0, exp_busy});
    check_val("b_valid_gap", {31'd0, ifb.dout_valid}, {31'd0, exp_valid});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifa.si = 1'b1; ifa.si_en = 1'b0; ifa.dout_ready = 1'b0; ifa.overrun_clr = 1'b0;
    ifb.si = 1'b1; ifb.si_en = 1'b0; ifb.dout_ready = 1'b0; ifb.overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_dout", {28'd0, ifa.dout}, 32'h0);
    check_val("rst_valid", {31'd0, ifa.dout_valid}, 32'h0);
    check_val("rst_perr", {31'd0, ifa.parity_err}, 32'h0);
    check_val("rst_ferr", {31'd0, ifa.frame_err}, 32'h0);
    check_val("rst_ovr", {31'd0, ifa.overrun}, 32'h0);
    check_val("rst_busy", {31'd0, ifa.busy}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of DATA
    bit_a(1'b0);
    bit_a(1'b1);
    bit_a(1'b0);
    check_val("mid_busy", {31'd0, ifa.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_busy", {31'd0, ifa.busy}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifa.si = 1'b1;
    ifa.si_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_val("idle_busy", {31'd0, ifa.busy}, 32'h0);
      check_val("idle_flags", {28'd0, ifa.dout_valid, ifa.frame_err, ifa.overrun, ifa.parity_err}, 32'h0);
    end

    // Good frame 1011, parity 1
    frame_a(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("good_dout", {28'd0, ifa.dout}, 32'hB);
    check_val("good_valid", {31'd0, ifa.dout_valid}, 32'h1);
    check_val("good_perr", {31'd0, ifa.parity_err}, 32'h0);
    check_val("good_busy", {31'd0, ifa.busy}, 32'h0);
    check_val("good_ferr", {31'd0, ifa.frame_err}, 32'h0);
    consume_a();
    check_val("consumed_valid", {31'd0, ifa.dout_valid}, 32'h0);
    check_val("consumed_dout", {28'd0, ifa.dout}, 32'hB);

    // Parity error, then a clean frame
    frame_a(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("perr_dout", {28'd0, ifa.dout}, 32'hB);
    check_val("perr_flag", {31'd0, ifa.parity_err}, 32'h1);
    consume_a();
    frame_a(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("perr2_dout", {28'd0, ifa.dout}, 32'h6);
    check_val("perr2_flag", {31'd0, ifa.parity_err}, 32'h0);
    consume_a();

    // Framing error, then recovery
    frame_a(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("ferr_pulse", {31'd0, ifa.frame_err}, 32'h1);
    check_val("ferr_valid", {31'd0, ifa.dout_valid}, 32'h0);
    check_val("ferr_busy", {31'd0, ifa.busy}, 32'h0);
    check_val("ferr_dout", {28'd0, ifa.dout}, 32'h6);
    @(posedge clk);
    #1;
    check_val("ferr_end", {31'd0, ifa.frame_err}, 32'h0);
    frame_a(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("after_ferr_dout", {28'd0, ifa.dout}, 32'h3);
    check_val("after_ferr_valid", {31'd0, ifa.dout_valid}, 32'h1);
    consume_a();

    // Overrun: two back-to-back frames, consumer stalled
    frame_a(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0);
    frame_a(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("ovr_dout", {28'd0, ifa.dout}, 32'h1);
    check_val("ovr_flag", {31'd0, ifa.overrun}, 32'h1);
    check_val("ovr_valid", {31'd0, ifa.dout_valid}, 32'h1);
    // Third frame lands on the accept cycle
    frame_a(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("swap_dout", {28'd0, ifa.dout}, 32'h7);
    check_val("swap_valid", {31'd0, ifa.dout_valid}, 32'h1);
    check_val("swap_perr", {31'd0, ifa.parity_err}, 32'h0);
    check_val("swap_ovr", {31'd0, ifa.overrun}, 32'h1);
    ifa.overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    ifa.overrun_clr = 1'b0;
    check_val("ovr_cleared", {31'd0, ifa.overrun}, 32'h0);
    // New overrun coincides with overrun_clr
    frame_a(4'b1111, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("ovr_set_wins", {31'd0, ifa.overrun}, 32'h1);
    check_val("ovr_hold_dout", {28'd0, ifa.dout}, 32'h7);
    consume_a();
    check_val("ovr_final_valid", {31'd0, ifa.dout_valid}, 32'h0);

    // No-parity instance with strobe every third cycle: frame 0,0,1,0,1,1
    bit_b(1'b0, 1'b1, 1'b0);
    bit_b(1'b0, 1'b1, 1'b0);
    bit_b(1'b1, 1'b1, 1'b0);
    bit_b(1'b0, 1'b1, 1'b0);
    bit_b(1'b1, 1'b1, 1'b0);
    bit_b(1'b1, 1'b0, 1'b1);
    check_val("b_dout", {28'd0, ifb.dout}, 32'h5);
    check_val("b_perr", {31'd0, ifb.parity_err}, 32'h0);
    check_val("b_ferr", {31'd0, ifb.frame_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame-level controller around the 4-bit serial-in/parallel-out shift datapath. It detects a start bit on the serial line and counts data bits into the shift chain. It checks the optional parity bit and the stop bit, then hands the assembled word to downstream logic over a valid/ready handshake. It sits between the serial input pin logic and the parallel consumer and owns all sequencing of when the shift chain is loaded and emptied.

## Interface
- WIDTH, 4, data bits per frame (2..16).
- PARITY_EN, 1, 1 = one even-parity bit follows the data bits; 0 = no parity bit.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- si  input  1  serial data; idle level 1.
- si_en  input  1  bit strobe; si is sampled only on cycles with si_en=1.
- dout  output  WIDTH  received word; first-received bit in dout[WIDTH-1], last in dout[0].
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
- parity_err  output  1  parity mismatch for the word in dout; meaningful only while dout_valid=1.
- frame_err  output  1  one-cycle pulse when a frame's stop bit is 0.
- overrun  output  1  sticky: a good frame was dropped because dout was still held.
- overrun_clr  input  1  clears overrun.
- busy  output  1  1 in any state other than IDLE.

## Operation
- Clock is clk. Reset is asynchronous and active-low on rst_n. Every register uses the same asynchronous reset.
- Reset values:
  - state = IDLE
  - shift register = 0
  - bit counter = 0
  - dout = 0
  - dout_valid = 0
  - parity_err = 0
  - frame_err = 0
  - overrun = 0
  - busy = 0
- State machine. Transitions occur only on cycles with si_en=1. With si_en=0, all state and the shift register hold.
  - IDLE: si=0 → DATA with counter cleared. si=1 → stay in IDLE.
  - DATA: shift register ← {shift[WIDTH-2:0], si}; counter+1. When the counter reaches WIDTH-1 and that bit is sampled → PARITY if PARITY_EN=1, else → STOP.
  - PARITY: capture si as the received parity bit → STOP.
  - STOP: si=1 is a good frame: attempt to load dout, then → IDLE. si=0 is a framing error: pulse frame_err for the next cycle, discard the word, do not change dout, dout_valid or overrun, then → IDLE.
- Parity rule: even parity. Computed error = XOR(data bits) ^ received parity bit. Forced to 0 when PARITY_EN=0.
- Load on good frame:
  - If dout_valid=0, or dout_valid & dout_ready in the same cycle: dout ← shift register, parity_err ← computed error, dout_valid ← 1.
  - Otherwise, dout_valid=1 and dout_ready=0: the word is dropped, dout and parity_err are unchanged, and overrun ← 1.
- Handshake:
  - dout_valid & dout_ready with no simultaneous load → dout_valid ← 0. dout keeps its value.
  - dout and parity_err are stable while dout_valid=1 and dout_ready=0.
- overrun:
  - overrun_clr=1 → overrun ← 0.
  - An overrun event in the same cycle as overrun_clr → overrun = 1 (set wins).
- A start bit is accepted only in IDLE. There is no mid-frame resynchronisation; a 0 seen in DATA is data.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is lost and no error flag is raised.
- Counter width is clog2(WIDTH). No wrap-around beyond WIDTH-1 is possible.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Minimum frame = 1 start + WIDTH data + PARITY_EN + 1 stop si_en strobes.
- dout_valid rises on the clock edge that samples the stop bit. It is visible in the first cycle after that si_en cycle.
- frame_err is high for exactly one cycle, the cycle after the stop-bit sample.
- busy rises the cycle after the start-bit sample. It falls the cycle after the stop-bit sample.
- Back-to-back frames are supported: a new start bit may be sampled on the si_en immediately after the stop bit.
- si_en may be held high continuously, giving one bit per clock.

## Test plan
- Reset/idle: assert rst_n=0 mid-DATA, release, hold si=1 with si_en=1 for 20 cycles → all outputs 0, busy=0 throughout.
- Good frame (WIDTH=4, PARITY_EN=1, si_en=1): si sequence 0,1,0,1,1,1,1 (start, data 1011, parity 1, stop 1) → dout=4'b1011, parity_err=0, dout_valid=1 one cycle after the stop sample. With dout_ready=1 for one cycle → dout_valid=0.
- Parity error: same frame with parity bit 0 → dout=4'b1011, parity_err=1. Second frame data 0110, parity 0 → parity_err=0.
- Framing error: frame with stop bit 0 → frame_err one-cycle pulse, dout_valid stays 0, busy=0 after. The following good frame with data 0011 → dout=4'b0011.
- Overrun and simultaneous events:
  - Two good frames back-to-back with dout_ready=0 → dout holds the first word, overrun=1.
  - Third frame completes in the cycle dout_ready=1 → dout = third word, dout_valid stays 1.
  - overrun_clr in the same cycle as a new overrun event → overrun stays 1.
- Strobe gating: PARITY_EN=0, si_en pulsed every 3rd cycle, frame 0,0,1,0,1,1 → dout=4'b0101. No state change on cycles with si_en=0.
